// File: rtl/fifo_sl_pkg.sv
// Shared definitions for the FIFO serial-link reader-side arbitration logic.
// OBI field widths and the index-width helper used to size master IDs.
package fifo_sl_pkg;

    localparam int BE_WIDTH       = 4;
    localparam int OBI_DATA_WIDTH = 32;
    localparam int OBI_ADDR_WIDTH = 32;

    // A single-master configuration still needs a 1-bit index to stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : fifo_sl_pkg

// File: rtl/fifo_rr_pick.sv
// Round-robin pick: lowest-index requester at or above ptr_i, wrapping to 0.
// Search runs over a doubled request vector so the wrap needs no special case.
module fifo_rr_pick
    import fifo_sl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   pick_o,
    output logic               any_req_o
);

    logic [2*NUM_REQ-1:0] dbl_req;
    logic [2*NUM_REQ-1:0] pos_mask;

    // Lower copy only counts at or above the pointer; upper copy is the wrap.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
        assign pos_mask[gi]           = (IDX_W'(gi) >= ptr_i);
        assign pos_mask[gi + NUM_REQ] = 1'b1;
    end

    assign dbl_req   = {req_i, req_i} & pos_mask;
    assign any_req_o = |req_i;

    always_comb begin
        logic found;
        found  = 1'b0;
        pick_o = '0;
        for (int i = 0; i < 2 * NUM_REQ; i++) begin
            if (!found && dbl_req[i]) begin
                found  = 1'b1;
                pick_o = IDX_W'(i % NUM_REQ);
            end
        end
    end

endmodule : fifo_rr_pick

// File: rtl/fifo_reader_rr_arbiter.sv
// Shares the FIFO reader OBI port among NUM_REQ masters with round-robin fairness.
// Reads go to the FIFO; writes are accepted and answered locally with rdata 0.
module fifo_reader_rr_arbiter
    import fifo_sl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = OBI_DATA_WIDTH,
    parameter int ADDR_WIDTH = OBI_ADDR_WIDTH
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REQ-1:0]             m_req_i,
    output logic [NUM_REQ-1:0]             m_gnt_o,
    output logic [NUM_REQ-1:0]             m_rvalid_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  m_addr_i,
    input  logic [NUM_REQ-1:0]             m_we_i,
    input  logic [NUM_REQ*BE_WIDTH-1:0]    m_be_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  m_wdata_i,
    output logic [DATA_WIDTH-1:0]          m_rdata_o,
    output logic                           s_req_o,
    input  logic                           s_gnt_i,
    input  logic                           s_rvalid_i,
    output logic [ADDR_WIDTH-1:0]          s_addr_o,
    output logic                           s_we_o,
    output logic [BE_WIDTH-1:0]            s_be_o,
    input  logic [DATA_WIDTH-1:0]          s_rdata_i,
    output logic [DATA_WIDTH-1:0]          s_wdata_o
);

    localparam int IDX_W = idx_w(NUM_REQ);

    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0]      rsp_id_q, rsp_id_d;
    logic                  rsp_local_q, rsp_local_d;

    logic [IDX_W-1:0]      pick;
    logic                  any_req;
    logic                  handshake;
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [BE_WIDTH-1:0]   be_arr   [NUM_REQ];

    // Write data is never forwarded; the FIFO reader port has no write path.
    logic unused_wdata;
    assign unused_wdata = ^m_wdata_i;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi] = m_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign be_arr[gi]   = m_be_i[gi*BE_WIDTH +: BE_WIDTH];
    end

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i     (m_req_i),
        .ptr_i     (rr_ptr_q),
        .pick_o    (pick),
        .any_req_o (any_req)
    );

    // Request side: grants and slave request are held low while in reset.
    always_comb begin
        m_gnt_o   = '0;
        s_req_o   = 1'b0;
        handshake = 1'b0;
        s_addr_o  = addr_arr[pick];
        s_be_o    = be_arr[pick];
        s_we_o    = 1'b0;
        s_wdata_o = '0;
        if (rst_ni && any_req) begin
            if (m_we_i[pick]) begin
                m_gnt_o[pick] = 1'b1;
                handshake     = 1'b1;
            end else begin
                s_req_o       = 1'b1;
                m_gnt_o[pick] = s_gnt_i;
                handshake     = s_gnt_i;
            end
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = handshake;
        rsp_id_d    = rsp_id_q;
        rsp_local_d = rsp_local_q;
        if (handshake) begin
            rr_ptr_d    = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
            rsp_id_d    = pick;
            rsp_local_d = m_we_i[pick];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_local_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_local_q <= rsp_local_d;
        end
    end

    // Response side: the FIFO answers exactly one cycle after its pop.
    always_comb begin
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        if (rsp_valid_q) begin
            m_rvalid_o[rsp_id_q] = rsp_local_q | s_rvalid_i;
            if (!rsp_local_q) begin
                m_rdata_o = s_rdata_i;
            end
        end
    end

    a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(m_gnt_o));
    a_rvalid_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(m_rvalid_o));
    a_rvalid_expected : assert property (@(posedge clk_i) disable iff (!rst_ni)
        s_rvalid_i |-> (rsp_valid_q && !rsp_local_q));

endmodule : fifo_reader_rr_arbiter

// File: tb/tb_fifo_reader_rr_arbiter.sv
// Bench for fifo_reader_rr_arbiter: directed scenarios plus a queue-based model
// checked on every falling edge, and a fairness stress at the end.
module tb_fifo_reader_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    m_req, m_gnt, m_rvalid, m_we;
    logic [N*AW-1:0] m_addr;
    logic [N*4-1:0]  m_be;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0]   m_rdata;
    logic            s_req, s_gnt, s_rvalid, s_we;
    logic [AW-1:0]   s_addr;
    logic [3:0]      s_be;
    logic [DW-1:0]   s_rdata, s_wdata;

    int nvec  = 0;
    int nfail = 0;

    // sq feeds the FIFO stand-in; mq is the model's own copy of the same contents.
    logic [31:0] sq[$];
    logic [31:0] mq[$];
    bit          slave_en;

    int          mptr;
    bit          mvalid, mlocal;
    int          mid;
    logic [31:0] mdata;

    always #5 clk = ~clk;

    fifo_reader_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .m_req_i    (m_req),
        .m_gnt_o    (m_gnt),
        .m_rvalid_o (m_rvalid),
        .m_addr_i   (m_addr),
        .m_we_i     (m_we),
        .m_be_i     (m_be),
        .m_wdata_i  (m_wdata),
        .m_rdata_o  (m_rdata),
        .s_req_o    (s_req),
        .s_gnt_i    (s_gnt),
        .s_rvalid_i (s_rvalid),
        .s_addr_o   (s_addr),
        .s_we_o     (s_we),
        .s_be_o     (s_be),
        .s_rdata_i  (s_rdata),
        .s_wdata_o  (s_wdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: round-robin from the spec rules, one response slot per handshake.
    always @(negedge clk) begin : model_cmp
        logic [N-1:0] eg, ev;
        logic         esreq;
        int           pick;
        bit           any;
        if (!rst_n) begin
            mptr = 0; mvalid = 0; mlocal = 0; mid = 0;
            chk("rst_gnt", 64'(m_gnt), 64'(0));
            chk("rst_rvalid", 64'(m_rvalid), 64'(0));
            chk("rst_rdata", 64'(m_rdata), 64'(0));
            chk("rst_sreq", 64'(s_req), 64'(0));
        end else begin
            any = 0; pick = 0;
            for (int k = 0; k < N; k++) begin
                if (!any && m_req[(mptr + k) % N]) begin
                    any  = 1;
                    pick = (mptr + k) % N;
                end
            end
            eg = '0; esreq = 0;
            if (any) begin
                if (m_we[pick]) eg[pick] = 1'b1;
                else begin esreq = 1'b1; eg[pick] = s_gnt; end
            end
            ev = mvalid ? (N'(1) << mid) : '0;
            chk("m_gnt", 64'(m_gnt), 64'(eg));
            chk("s_req", 64'(s_req), 64'(esreq));
            chk("m_rvalid", 64'(m_rvalid), 64'(ev));
            chk("s_we", 64'(s_we), 64'(0));
            chk("s_wdata", 64'(s_wdata), 64'(0));
            if (esreq) begin
                chk("s_addr", 64'(s_addr), 64'(m_addr[pick*AW +: AW]));
                chk("s_be", 64'(s_be), 64'(m_be[pick*4 +: 4]));
            end
            if (mvalid) chk("m_rdata", 64'(m_rdata), mlocal ? 64'(0) : 64'(mdata));
            if (eg != '0) begin
                mptr   = (pick + 1) % N;
                mvalid = 1;
                mid    = pick;
                mlocal = m_we[pick];
                if (!mlocal && mq.size() != 0) mdata = mq.pop_front();
            end else begin
                mvalid = 0;
            end
        end
    end

    task automatic load(input logic [31:0] d);
        sq.push_back(d);
        mq.push_back(d);
    endtask

    task automatic settle();
        s_gnt = slave_en && (sq.size() != 0);
        #3;
    endtask

    // FIFO stand-in: pops on handshake, answers with data one cycle later.
    task automatic tick();
        bit pop;
        pop = rst_n && s_req && s_gnt;
        @(posedge clk);
        #1;
        s_rvalid = pop;
        if (pop) s_rdata = sq.pop_front();
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    logic [N-1:0] exp_g [5];
    int           gcnt  [N];
    int           gmin, gmax;

    initial begin
        rst_n = 0; m_req = '0; m_we = '0; m_be = '0; m_wdata = '0;
        s_gnt = 0; s_rvalid = 0; s_rdata = '0; slave_en = 1;
        for (int i = 0; i < N; i++) begin
            m_addr[i*AW +: AW] = 32'h1000_0000 + 32'(i) * 32'h10;
            m_be[i*4 +: 4]     = 4'(4'hF >> i);
        end
        m_wdata[1*DW +: DW] = 32'hDEAD;
        @(posedge clk);
        #1;

        // Reset with every master requesting; outputs stay quiet.
        load(32'h1111_0000);
        m_req = 4'hF;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t1_rst_gnt", 64'(m_gnt), 64'(0));
            chk("t1_rst_sreq", 64'(s_req), 64'(0));
            tick();
        end
        rst_n = 1;
        settle();
        chk("t1_first_gnt", 64'(m_gnt), 64'(4'b0001));
        tick();
        m_req = '0;
        settle();
        chk("t1_rvalid", 64'(m_rvalid), 64'(4'b0001));
        chk("t1_rdata", 64'(m_rdata), 64'(32'h1111_0000));
        tick();

        // All four read continuously: grants rotate m0..m3, m0.
        rst_n = 0; cycle(); cycle(); rst_n = 1;
        for (int k = 0; k < 5; k++) load(32'hA000_0001 + 32'(k));
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            m_req = (k < 5) ? 4'hF : 4'h0;
            settle();
            if (k < 5) chk("t2_gnt", 64'(m_gnt), 64'(exp_g[k]));
            if (k > 0) begin
                chk("t2_rvalid", 64'(m_rvalid), 64'(exp_g[k-1]));
                chk("t2_rdata", 64'(m_rdata), 64'(32'hA000_0001 + 32'(k - 1)));
            end
            tick();
        end

        // Pointer sits at 2 after an m1 grant; FIFO empty for five cycles.
        load(32'hB000_0001);
        m_req = 4'b0010;
        settle();
        chk("t3_m1_gnt", 64'(m_gnt), 64'(4'b0010));
        tick();
        m_req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t3_empty_gnt", 64'(m_gnt), 64'(0));
            chk("t3_empty_sreq", 64'(s_req), 64'(1));
            tick();
        end
        load(32'hC000_0001); load(32'hC000_0002);
        m_req = 4'b0101;
        settle();
        chk("t3_m2_first", 64'(m_gnt), 64'(4'b0100));
        tick();
        m_req = 4'b0001;
        settle();
        chk("t3_m0_next", 64'(m_gnt), 64'(4'b0001));
        chk("t3_m2_rdata", 64'(m_rdata), 64'(32'hC000_0001));
        tick();
        m_req = '0;
        settle();
        chk("t3_m0_rvalid", 64'(m_rvalid), 64'(4'b0001));
        chk("t3_m0_rdata", 64'(m_rdata), 64'(32'hC000_0002));
        tick();

        // Local write from m1: no FIFO traffic, zero read data.
        load(32'hD000_0001);
        m_req = 4'b0010; m_we = 4'b0010;
        settle();
        chk("t4_wr_gnt", 64'(m_gnt), 64'(4'b0010));
        chk("t4_wr_sreq", 64'(s_req), 64'(0));
        tick();
        m_req = '0; m_we = '0;
        settle();
        chk("t4_wr_rvalid", 64'(m_rvalid), 64'(4'b0010));
        chk("t4_wr_rdata", 64'(m_rdata), 64'(0));
        chk("t4_fifo_kept", 64'(sq.size()), 64'(1));
        tick();

        // Interleaved m3 writes and an m0 read, back to back.
        load(32'hE000_0001);
        m_req = 4'b1001; m_we = 4'b1000;
        settle();
        chk("t5_m3_gnt", 64'(m_gnt), 64'(4'b1000));
        tick();
        m_req = 4'b0001; m_we = 4'b0000;
        settle();
        chk("t5_m0_gnt", 64'(m_gnt), 64'(4'b0001));
        chk("t5_m3_rvalid", 64'(m_rvalid), 64'(4'b1000));
        chk("t5_m3_rdata", 64'(m_rdata), 64'(0));
        tick();
        m_req = 4'b1000; m_we = 4'b1000;
        settle();
        chk("t5_m3_gnt2", 64'(m_gnt), 64'(4'b1000));
        chk("t5_m0_rvalid", 64'(m_rvalid), 64'(4'b0001));
        chk("t5_m0_rdata", 64'(m_rdata), 64'(32'hD000_0001));
        tick();
        m_req = '0; m_we = '0;
        settle();
        chk("t5_m3_rvalid2", 64'(m_rvalid), 64'(4'b1000));
        tick();

        // Reset right after a read grant discards the pending response.
        m_req = 4'b0001;
        settle();
        chk("t6_gnt", 64'(m_gnt), 64'(4'b0001));
        tick();
        rst_n = 0; m_req = '0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t6_rst_rvalid", 64'(m_rvalid), 64'(0));
            tick();
        end
        rst_n = 1;
        settle();
        chk("t6_post_rvalid", 64'(m_rvalid), 64'(0));
        tick();
        load(32'hF000_0001);
        m_req = 4'hF;
        settle();
        chk("t6_ptr_zero", 64'(m_gnt), 64'(4'b0001));
        tick();

        // Stress: all masters requesting, random op kinds and FIFO stalls.
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        for (int c = 0; c < 1000; c++) begin
            if (sq.size() < 3) load($urandom);
            slave_en = ($urandom_range(0, 3) != 0);
            m_we     = 4'($urandom);
            m_be     = 16'($urandom);
            m_addr   = {$urandom, $urandom, $urandom, $urandom};
            m_req    = 4'hF;
            settle();
            for (int i = 0; i < N; i++) if (m_gnt[i]) gcnt[i]++;
            tick();
        end
        slave_en = 1; m_req = '0; m_we = '0;
        cycle(); cycle();
        gmin = gcnt[0]; gmax = gcnt[0];
        for (int i = 1; i < N; i++) begin
            if (gcnt[i] < gmin) gmin = gcnt[i];
            if (gcnt[i] > gmax) gmax = gcnt[i];
        end
        $display("stress grants m0=%0d m1=%0d m2=%0d m3=%0d", gcnt[0], gcnt[1], gcnt[2], gcnt[3]);
        chk("stress_fairness", 64'(gmax - gmin <= 1), 64'(1));
        chk("stress_progress", 64'(gmin > 100), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule : tb_fifo_reader_rr_arbiter
